// File: rtl/fetch_unit_if.sv
// fetch_unit_if: request/acknowledge read port between the fetch unit and instruction memory
interface fetch_unit_if #(
    parameter int ADDR_W = 16
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [31:0]       rdata;
    modport master(output req, addr, input ack, rdata);
    modport slave(input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: holds the PC, fetches one instruction word per PC value into IR
// and applies control-unit PC updates; IR fields are sliced out combinationally.
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_im,
    input  logic              w_pc,
    input  logic              s_mxpc,
    input  logic [ADDR_W-1:0] target,
    fetch_unit_if.master      im,
    output logic [ADDR_W-1:0] pc,
    output logic              ir_valid,
    output logic              im_err,
    output logic [2:0]        itype,
    output logic [4:0]        op,
    output logic [3:0]        rd,
    output logic [3:0]        ra,
    output logic [3:0]        rb,
    output logic [15:0]       imm
);
    typedef enum logic {IDLE, REQ} state_t;
    state_t            state, state_n;
    logic [ADDR_W-1:0] pc_n, im_addr, im_addr_n;
    logic [31:0]       ir, ir_n;
    logic [7:0]        cnt, cnt_n;
    logic              ir_valid_n, fetched, fetched_n, err_n, stale, stale_n;
    logic              start, timeout, done;
    assign im.req  = state == REQ;
    assign im.addr = im_addr;
    assign itype   = ir[31:29];
    assign op      = ir[28:24];
    assign rd      = ir[23:20];
    assign ra      = ir[19:16];
    assign rb      = ir[15:12];
    assign imm     = ir[15:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            ir       <= '0;
            ir_valid <= 1'b0;
            fetched  <= 1'b0;
            im_addr  <= '0;
            im_err   <= 1'b0;
            cnt      <= '0;
            stale    <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ir       <= ir_n;
            ir_valid <= ir_valid_n;
            fetched  <= fetched_n;
            im_addr  <= im_addr_n;
            im_err   <= err_n;
            cnt      <= cnt_n;
            stale    <= stale_n;
        end
    end
    // stale marks a fetch whose PC was rewritten while it was in flight
    always_comb begin
        start      = state == IDLE && w_im && !fetched;
        timeout    = state == REQ && !im.ack && cnt == 8'(TIMEOUT - 1);
        done       = state == REQ && (im.ack || timeout);
        state_n    = start ? REQ : done ? IDLE : state;
        im_addr_n  = start ? pc : im_addr;
        cnt_n      = start ? 8'd0 : state == REQ ? cnt + 8'd1 : cnt;
        stale_n    = start ? w_pc : stale | w_pc;
        ir_n       = !done ? ir : im.ack ? im.rdata : 32'd0;
        err_n      = im_err | timeout;
        ir_valid_n = w_pc ? 1'b0 : done ? !stale : ir_valid;
        fetched_n  = w_pc ? 1'b0 : done ? !stale : fetched;
        pc_n       = w_pc ? (s_mxpc ? target : pc + 1'b1) : pc;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetch scenarios; expected request addresses and IR
// contents are queued by the stimulus and checked by an independent monitor.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        w_im = 1'b0, w_pc = 1'b0, s_mxpc = 1'b0;
    logic [15:0] target = '0;
    logic [15:0] pc;
    logic        ir_valid, im_err;
    logic [2:0]  itype;
    logic [4:0]  op;
    logic [3:0]  rd, ra, rb;
    logic [15:0] imm;
    int          total = 0, bad = 0, req_count = 0;
    logic [15:0] addr_q[$];
    logic [32:0] ir_q[$];

    fetch_unit_if #(.ADDR_W(16)) im();

    fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .w_im(w_im), .w_pc(w_pc), .s_mxpc(s_mxpc),
        .target(target), .im(im), .pc(pc), .ir_valid(ir_valid), .im_err(im_err),
        .itype(itype), .op(op), .rd(rd), .ra(ra), .rb(rb), .imm(imm)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req();
        int i;
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (im.req) break;
        end
        check("req_seen", 64'(im.req), 64'd1);
    endtask

    task automatic pc_write(input logic sel, input logic [15:0] tgt);
        w_pc = 1'b1;
        s_mxpc = sel;
        target = tgt;
        @(negedge clk);
        w_pc = 1'b0;
    endtask

    task automatic do_fetch(input logic [15:0] a, input logic [31:0] d, input int delay, input logic err);
        addr_q.push_back(a);
        ir_q.push_back({err, d});
        w_im = 1'b1;
        wait_req();
        w_im = 1'b0;
        cyc(delay);
        im.ack = 1'b1;
        im.rdata = d;
        @(negedge clk);
        im.ack = 1'b0;
    endtask

    // monitor: compares every new request and every newly valid IR against the queues
    initial begin
        logic        prev_req, prev_valid;
        logic [15:0] cur_addr;
        logic [32:0] e;
        prev_req = 1'b0;
        prev_valid = 1'b0;
        cur_addr = '0;
        forever begin
            @(negedge clk);
            if (im.req && !prev_req) begin
                req_count++;
                if (addr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_req addr=%0h", im.addr);
                end else cur_addr = addr_q.pop_front();
            end
            if (im.req) check("im_addr", 64'(im.addr), 64'(cur_addr));
            if (ir_valid && !prev_valid) begin
                if (ir_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ir_valid ir_imm=%0h", imm);
                end else begin
                    e = ir_q.pop_front();
                    check("ir_fields", 64'({im_err, itype, op, rd, ra, imm}), 64'(e));
                    check("rb", 64'(rb), 64'(e[15:12]));
                end
            end
            prev_req = im.req;
            prev_valid = ir_valid;
        end
    end

    initial begin
        int n;
        im.ack = 1'b0;
        im.rdata = '0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        check("rst_pc", 64'(pc), 64'h0);
        check("rst_valid", 64'(ir_valid), 64'h0);
        check("rst_req", 64'(im.req), 64'h0);
        check("rst_err", 64'(im_err), 64'h0);
        // basic fetch, ACK two cycles into the request
        do_fetch(16'h0000, 32'h2A1F0000, 2, 1'b0);
        check("t1_valid", 64'(ir_valid), 64'h1);
        check("t1_type", 64'(itype), 64'h1);
        check("t1_op", 64'(op), 64'h0A);
        check("t1_reqs", 64'(req_count), 64'h1);
        // held fetch enable must not refetch
        w_im = 1'b1;
        cyc(10);
        w_im = 1'b0;
        check("t2_reqs", 64'(req_count), 64'h1);
        check("t2_req", 64'(im.req), 64'h0);
        // PC wrap and jump
        pc_write(1'b1, 16'hFFFF);
        check("t3_pc_ffff", 64'(pc), 64'hFFFF);
        check("t3_valid_clr", 64'(ir_valid), 64'h0);
        pc_write(1'b0, 16'h1234);
        check("t3_wrap", 64'(pc), 64'h0000);
        pc_write(1'b1, 16'h0100);
        check("t3_jump", 64'(pc), 64'h0100);
        do_fetch(16'h0100, 32'h12345678, 0, 1'b0);
        check("t3_valid", 64'(ir_valid), 64'h1);
        // timeout
        pc_write(1'b1, 16'h0200);
        addr_q.push_back(16'h0200);
        ir_q.push_back({1'b1, 32'h0});
        w_im = 1'b1;
        wait_req();
        w_im = 1'b0;
        n = 0;
        while (im.req && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("t4_req_cycles", 64'(n), 64'd15);
        check("t4_valid", 64'(ir_valid), 64'h1);
        check("t4_err", 64'(im_err), 64'h1);
        check("t4_ir_nop", 64'({itype, op, rd, ra, imm}), 64'h0);
        pc_write(1'b0, 16'h0000);
        check("t4_pc_inc", 64'(pc), 64'h0201);
        do_fetch(16'h0201, 32'hE3456789, 1, 1'b1);
        check("t4_err_sticky", 64'(im_err), 64'h1);
        // PC rewritten while a fetch is in flight
        pc_write(1'b1, 16'h0010);
        addr_q.push_back(16'h0010);
        w_im = 1'b1;
        wait_req();
        w_im = 1'b0;
        pc_write(1'b1, 16'h0040);
        check("t5_pc", 64'(pc), 64'h0040);
        check("t5_addr_held", 64'(im.addr), 64'h0010);
        check("t5_req_held", 64'(im.req), 64'h1);
        im.ack = 1'b1;
        im.rdata = 32'h55AA1234;
        @(negedge clk);
        im.ack = 1'b0;
        check("t5_valid", 64'(ir_valid), 64'h0);
        check("t5_req_drop", 64'(im.req), 64'h0);
        check("t5_ir_captured", 64'({itype, imm}), 64'h21234);
        do_fetch(16'h0040, 32'h0BADF00D, 1, 1'b1);
        check("t5_valid2", 64'(ir_valid), 64'h1);
        // asynchronous reset during a request
        pc_write(1'b1, 16'h0300);
        addr_q.push_back(16'h0300);
        w_im = 1'b1;
        wait_req();
        w_im = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t6_req_async", 64'(im.req), 64'h0);
        check("t6_pc_async", 64'(pc), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        im.ack = 1'b1;
        im.rdata = 32'hFFFFFFFF;
        cyc(2);
        im.ack = 1'b0;
        cyc(1);
        check("t6_ir", 64'({itype, op, rd, ra, imm}), 64'h0);
        check("t6_valid", 64'(ir_valid), 64'h0);
        check("t6_err", 64'(im_err), 64'h0);
        check("t6_req", 64'(im.req), 64'h0);
        check("addr_q_empty", 64'(addr_q.size()), 64'h0);
        check("ir_q_empty", 64'(ir_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
